// File: rtl/cpu_pkg.sv
// Shared CPU definitions: fetch FSM states, reset PC and the opcode/funct
// encodings used by the fetch unit, decoder and controller.
package cpu_pkg;

    localparam int          DATA_W           = 32;
    localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        HOLD = 2'd2
    } fetch_state_t;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_JAL   = 6'h03;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_BNE   = 6'h05;
    localparam logic [5:0] FUNCT_JR = 6'h08;

    function automatic logic [DATA_W-1:0] word_align(input logic [DATA_W-1:0] addr);
        return {addr[DATA_W-1:2], 2'b00};
    endfunction

endpackage

// File: rtl/instruction_fetch_if.sv
// Bus bundle of the fetch unit: instruction-memory req/ack port plus the
// decoder-side valid/ready port with its redirect controls.
interface instruction_fetch_if
    import cpu_pkg::*;
;
    logic              imem_req;
    logic [DATA_W-1:0] imem_addr;
    logic              imem_ack;
    logic [DATA_W-1:0] imem_rdata;

    logic [DATA_W-1:0] instruction;
    logic [DATA_W-1:0] old_pc_plus_4;
    logic              inst_valid;
    logic              inst_ready;
    logic              branch;
    logic              nbranch;
    logic              jmp;
    logic              jal;
    logic              jr;
    logic              zero;
    logic [DATA_W-1:0] read_data_1;
    logic [DATA_W-1:0] sign_extend;
    logic              addr_misaligned;

    modport master (
        output imem_req, imem_addr, instruction, old_pc_plus_4, inst_valid, addr_misaligned,
        input  imem_ack, imem_rdata, inst_ready, branch, nbranch, jmp, jal, jr, zero,
               read_data_1, sign_extend
    );

    modport slave (
        input  imem_req, imem_addr, instruction, old_pc_plus_4, inst_valid, addr_misaligned,
        output imem_ack, imem_rdata, inst_ready, branch, nbranch, jmp, jal, jr, zero,
               read_data_1, sign_extend
    );

endinterface

// File: rtl/pc_next_logic.sv
// Combinational next-PC selection for the retiring instruction:
// jr > jmp/jal > taken branch > sequential.
module pc_next_logic
    import cpu_pkg::*;
(
    input  logic [DATA_W-1:0]        old_pc_plus_4_i,
    input  logic [25:0]              jump_target_i,
    input  logic                     branch_i,
    input  logic                     nbranch_i,
    input  logic                     jmp_i,
    input  logic                     jal_i,
    input  logic                     jr_i,
    input  logic                     zero_i,
    input  logic [DATA_W-1:0]        read_data_1_i,
    input  logic signed [DATA_W-1:0] sign_extend_i,
    output logic [DATA_W-1:0]        next_pc_o,
    output logic                     misaligned_o
);

    logic signed [DATA_W-1:0] branch_off;
    logic                     take_branch;

    always_comb begin
        // Word offset becomes a byte offset; the add wraps modulo 2^32.
        branch_off   = sign_extend_i <<< 2;
        take_branch  = (branch_i & zero_i) | (nbranch_i & ~zero_i);
        misaligned_o = jr_i & (read_data_1_i[1:0] != 2'b00);

        if (jr_i) begin
            next_pc_o = word_align(read_data_1_i);
        end else if (jmp_i | jal_i) begin
            next_pc_o = {old_pc_plus_4_i[31:28], jump_target_i, 2'b00};
        end else if (take_branch) begin
            next_pc_o = old_pc_plus_4_i + $unsigned(branch_off);
        end else begin
            next_pc_o = old_pc_plus_4_i;
        end
    end

endmodule

// File: rtl/instruction_fetch.sv
// Instruction fetch unit: owns the PC, fetches over imem req/ack and holds
// each word for the decoder until it retires, then redirects the PC.
module instruction_fetch
    import cpu_pkg::*;
#(
    parameter logic [DATA_W-1:0] RESET_PC = RESET_PC_DEFAULT
) (
    input  logic clk,
    input  logic rst,
    instruction_fetch_if.master bus
);

    fetch_state_t      state_q;
    logic [DATA_W-1:0] pc_q;
    logic [DATA_W-1:0] instruction_q;
    logic [DATA_W-1:0] old_pc_plus_4_q;
    logic              imem_req_q;
    logic              inst_valid_q;
    logic              misaligned_q;

    logic [DATA_W-1:0] next_pc_d;
    logic              misaligned_d;

    pc_next_logic u_pc_next (
        .old_pc_plus_4_i (old_pc_plus_4_q),
        .jump_target_i   (instruction_q[25:0]),
        .branch_i        (bus.branch),
        .nbranch_i       (bus.nbranch),
        .jmp_i           (bus.jmp),
        .jal_i           (bus.jal),
        .jr_i            (bus.jr),
        .zero_i          (bus.zero),
        .read_data_1_i   (bus.read_data_1),
        .sign_extend_i   (bus.sign_extend),
        .next_pc_o       (next_pc_d),
        .misaligned_o    (misaligned_d)
    );

    // Async reset clears req/valid at once, so an in-flight fetch is dropped
    // and any ack arriving afterwards meets IDLE and is ignored.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q         <= IDLE;
            pc_q            <= word_align(RESET_PC);
            instruction_q   <= '0;
            old_pc_plus_4_q <= '0;
            imem_req_q      <= 1'b0;
            inst_valid_q    <= 1'b0;
            misaligned_q    <= 1'b0;
        end else begin
            misaligned_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    state_q    <= REQ;
                    imem_req_q <= 1'b1;
                end
                REQ: begin
                    if (bus.imem_ack) begin
                        instruction_q   <= bus.imem_rdata;
                        old_pc_plus_4_q <= pc_q + 32'd4;
                        imem_req_q      <= 1'b0;
                        inst_valid_q    <= 1'b1;
                        state_q         <= HOLD;
                    end
                end
                HOLD: begin
                    if (bus.inst_ready) begin
                        pc_q         <= next_pc_d;
                        misaligned_q <= misaligned_d;
                        inst_valid_q <= 1'b0;
                        imem_req_q   <= 1'b1;
                        state_q      <= REQ;
                    end
                end
                default: begin
                    state_q      <= IDLE;
                    imem_req_q   <= 1'b0;
                    inst_valid_q <= 1'b0;
                end
            endcase
        end
    end

    assign bus.imem_req        = imem_req_q;
    assign bus.imem_addr       = pc_q;
    assign bus.instruction     = instruction_q;
    assign bus.old_pc_plus_4   = old_pc_plus_4_q;
    assign bus.inst_valid      = inst_valid_q;
    assign bus.addr_misaligned = misaligned_q;

endmodule

// File: tb/tb_instruction_fetch.sv
// Scoreboard bench for instruction_fetch: expected fetch addresses and held
// words are queued as stimulus is driven and checked when the DUT shows them.
module tb_instruction_fetch;

    logic clk;
    logic rst;

    instruction_fetch_if bus ();

    instruction_fetch #(.RESET_PC(32'h0000_0000)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    logic [31:0] addr_q[$];
    logic [63:0] data_q[$];
    logic        prev_req   = 1'b0;
    logic        prev_valid = 1'b0;
    logic [31:0] last_rdata = 32'h0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", tag, obs, exp);
        end
    endtask

    // Advance one clock and sample 1 time unit after the edge; new requests
    // and newly valid instructions are checked against the scoreboard.
    task automatic tick();
        logic [31:0] ea;
        logic [63:0] ed;
        @(posedge clk);
        #1;
        if (bus.imem_req && !prev_req) begin
            if (addr_q.size() == 0) chk("addr_sb_empty", 32'd1, 32'd0);
            else begin
                ea = addr_q.pop_front();
                chk("imem_addr", bus.imem_addr, ea);
            end
        end
        if (bus.inst_valid && !prev_valid) begin
            if (data_q.size() == 0) chk("data_sb_empty", 32'd1, 32'd0);
            else begin
                ed = data_q.pop_front();
                chk("instruction", bus.instruction, ed[63:32]);
                chk("old_pc_plus_4", bus.old_pc_plus_4, ed[31:0]);
            end
        end
        prev_req   = bus.imem_req;
        prev_valid = bus.inst_valid;
    endtask

    task automatic clear_ctl();
        bus.inst_ready  = 1'b0;
        bus.branch      = 1'b0;
        bus.nbranch     = 1'b0;
        bus.jmp         = 1'b0;
        bus.jal         = 1'b0;
        bus.jr          = 1'b0;
        bus.zero        = 1'b0;
        bus.read_data_1 = 32'h0;
        bus.sign_extend = 32'h0;
    endtask

    // Serve one fetch at the expected pc after `waits` non-ack cycles; during
    // the wait the decoder side pokes inst_ready/jr, which REQ must ignore.
    task automatic fetch(input logic [31:0] pc, input logic [31:0] rdata, input int waits);
        int budget;
        budget = 0;
        while (!bus.imem_req && budget < 10) begin
            tick();
            budget++;
        end
        if (!bus.imem_req) chk("req_timeout", 32'd0, 32'd1);
        for (int w = 0; w < waits; w++) begin
            bus.imem_ack    = 1'b0;
            bus.inst_ready  = 1'b1;
            bus.jr          = 1'b1;
            bus.read_data_1 = 32'hDEAD_BEE0;
            tick();
            chk("wait_req", {31'd0, bus.imem_req}, 32'd1);
            chk("wait_addr", bus.imem_addr, pc);
        end
        clear_ctl();
        bus.imem_ack   = 1'b1;
        bus.imem_rdata = rdata;
        data_q.push_back({rdata, pc + 32'd4});
        last_rdata = rdata;
        tick();
        bus.imem_ack = 1'b0;
        chk("hold_valid", {31'd0, bus.inst_valid}, 32'd1);
        chk("misaligned_quiet", {31'd0, bus.addr_misaligned}, 32'd0);
    endtask

    // Retire the held word after `stall` not-ready cycles; ctl = {branch,nbranch,jmp,jal,jr}.
    task automatic retire(input logic [4:0] ctl, input logic zero, input logic [31:0] rd1,
                          input logic [31:0] se, input logic [31:0] exp_next,
                          input int stall, input logic exp_mis);
        for (int s = 0; s < stall; s++) begin
            bus.imem_ack   = 1'b1;
            bus.imem_rdata = 32'hBAD0_BAD0;
            tick();
            chk("stall_instr", bus.instruction, last_rdata);
            chk("stall_no_req", {31'd0, bus.imem_req}, 32'd0);
            chk("stall_valid", {31'd0, bus.inst_valid}, 32'd1);
        end
        bus.imem_ack    = 1'b0;
        bus.inst_ready  = 1'b1;
        {bus.branch, bus.nbranch, bus.jmp, bus.jal, bus.jr} = ctl;
        bus.zero        = zero;
        bus.read_data_1 = rd1;
        bus.sign_extend = se;
        addr_q.push_back(exp_next);
        tick();
        clear_ctl();
        chk("retire_valid_low", {31'd0, bus.inst_valid}, 32'd0);
        chk("addr_misaligned", {31'd0, bus.addr_misaligned}, {31'd0, exp_mis});
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: got running, expected finished");
        $fatal(1, "timeout");
    end

    initial begin
        logic [31:0] exp_pc;
        rst = 1'b1;
        bus.imem_ack   = 1'b0;
        bus.imem_rdata = 32'h0;
        clear_ctl();
        addr_q.push_back(32'h0000_0000);
        tick();
        tick();
        chk("rst_req", {31'd0, bus.imem_req}, 32'd0);
        chk("rst_addr", bus.imem_addr, 32'h0000_0000);
        chk("rst_instr", bus.instruction, 32'h0);
        chk("rst_pc4", bus.old_pc_plus_4, 32'h0);
        chk("rst_valid", {31'd0, bus.inst_valid}, 32'd0);
        chk("rst_misaligned", {31'd0, bus.addr_misaligned}, 32'd0);

        // Sequential fetch with ack and ready held high throughout.
        rst = 1'b0;
        exp_pc = 32'h0;
        bus.imem_ack   = 1'b1;
        bus.inst_ready = 1'b1;
        bus.imem_rdata = 32'hC0DE_0000;
        chk("idle_req", {31'd0, bus.imem_req}, 32'd0);
        for (int i = 0; i <= 8; i++) begin
            if (i % 2 == 1) data_q.push_back({32'hC0DE_0000 + exp_pc, exp_pc + 32'd4});
            if (i % 2 == 0 && i > 0) begin
                exp_pc = exp_pc + 32'd4;
                addr_q.push_back(exp_pc);
                bus.imem_rdata = 32'hC0DE_0000 + exp_pc;
            end
            tick();
            chk("seq_valid", {31'd0, bus.inst_valid}, {31'd0, i % 2 == 1});
            chk("seq_req", {31'd0, bus.imem_req}, {31'd0, i % 2 == 0});
        end
        bus.imem_ack   = 1'b0;
        bus.inst_ready = 1'b0;

        // Branches: taken beq backwards, untaken bne, taken bne, untaken beq.
        fetch(32'h0000_0010, 32'h1000_FFFE, 0);
        retire(5'b10000, 1'b1, 32'h0, 32'hFFFF_FFFE, 32'h0000_000C, 0, 1'b0);
        fetch(32'h0000_000C, 32'h1400_0003, 0);
        retire(5'b01000, 1'b1, 32'h0, 32'h0000_0003, 32'h0000_0010, 0, 1'b0);
        fetch(32'h0000_0010, 32'h1400_0004, 0);
        retire(5'b01000, 1'b0, 32'h0, 32'h0000_0004, 32'h0000_0024, 0, 1'b0);
        fetch(32'h0000_0024, 32'h1000_0007, 0);
        retire(5'b10000, 1'b0, 32'h0, 32'h0000_0007, 32'h0000_0028, 0, 1'b0);

        // Jumps: jr to high region, jal, j, misaligned jr, jr beating a branch.
        fetch(32'h0000_0028, 32'h0000_0008, 0);
        retire(5'b00001, 1'b0, 32'h1000_0000, 32'h0, 32'h1000_0000, 0, 1'b0);
        fetch(32'h1000_0000, 32'h0C00_0040, 0);
        retire(5'b00010, 1'b0, 32'h0, 32'h0, 32'h1000_0100, 0, 1'b0);
        fetch(32'h1000_0100, 32'h0800_0080, 0);
        retire(5'b00100, 1'b0, 32'h0, 32'h0, 32'h1000_0200, 0, 1'b0);
        fetch(32'h1000_0200, 32'h0000_0008, 0);
        retire(5'b00001, 1'b0, 32'h0000_0203, 32'h0, 32'h0000_0200, 0, 1'b1);
        fetch(32'h0000_0200, 32'h0000_0008, 0);
        retire(5'b10001, 1'b1, 32'h0000_0400, 32'h0000_0008, 32'h0000_0400, 0, 1'b0);

        // Memory wait states and decoder stall.
        fetch(32'h0000_0400, 32'h2222_3333, 3);
        retire(5'b00000, 1'b0, 32'h0, 32'h0, 32'h0000_0404, 4, 1'b0);

        // Wrap from the top of the address space.
        fetch(32'h0000_0404, 32'h0000_0008, 0);
        retire(5'b00001, 1'b0, 32'hFFFF_FFFC, 32'h0, 32'hFFFF_FFFC, 0, 1'b0);
        fetch(32'hFFFF_FFFC, 32'h4444_5555, 0);
        retire(5'b00000, 1'b0, 32'h0, 32'h0, 32'h0000_0000, 0, 1'b0);
        fetch(32'h0000_0000, 32'h6666_7777, 0);
        retire(5'b00000, 1'b0, 32'h0, 32'h0, 32'h0000_0004, 0, 1'b0);

        // Async reset mid-REQ, with a late ack that must be ignored.
        #3;
        rst = 1'b1;
        #1;
        chk("async_req_drop", {31'd0, bus.imem_req}, 32'd0);
        chk("async_valid", {31'd0, bus.inst_valid}, 32'd0);
        chk("async_addr", bus.imem_addr, 32'h0000_0000);
        bus.imem_ack   = 1'b1;
        bus.imem_rdata = 32'hDEAD_DEAD;
        tick();
        tick();
        rst = 1'b0;
        chk("restart_idle", {31'd0, bus.imem_req}, 32'd0);
        addr_q.push_back(32'h0000_0000);
        tick();
        bus.imem_ack = 1'b0;
        chk("late_ack_ignored", {31'd0, bus.inst_valid}, 32'd0);
        fetch(32'h0000_0000, 32'h8888_9999, 0);
        retire(5'b00000, 1'b0, 32'h0, 32'h0, 32'h0000_0004, 0, 1'b0);

        chk("addr_sb_left", addr_q.size(), 32'd0);
        chk("data_sb_left", data_q.size(), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
